// File: rtl/shift_sequencer.sv
// shift_sequencer: command-driven controller for a 4-bit universal shift
// register. Each accepted command parallel-loads a word, shifts it a given
// number of places left or right, then pulses done for one cycle.
//
// Optional build macro: SHIFT_SEQ_ROTATE_EN
//   When defined, the serial input during shifting is taken from the
//   register's own end bit (sr_q), so the register rotates and the fill bit
//   is ignored. When undefined, sr_q is unused and the fill bit shifts in.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] sr_q,
  output logic [1:0]       select,
  output logic [WIDTH-1:0] par_out,
  output logic             serial_R,
  output logic             serial_L,
  output logic             busy,
  output logic             done
);

  // Register select encodings understood by the downstream shift register.
  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // Command fields captured at acceptance; later changes on the command
  // inputs do not disturb a sequence in flight.
  logic [WIDTH-1:0] data_r;
  logic             dir_r;
  logic             fill_r;
  logic [CNT_W-1:0] cnt_r;

  logic             accept;
  logic             active_in;

  // Direction bit to shift select code.
  function automatic logic [1:0] shift_select(input logic dir);
    return dir ? SEL_LEFT : SEL_RIGHT;
  endfunction

  assign accept = cmd_valid & cmd_ready;

  // Bit presented on the active serial input while shifting.
`ifdef SHIFT_SEQ_ROTATE_EN
  // Rotation: right shift recirculates the LSB into the MSB, left shift
  // recirculates the MSB into the LSB. The captured fill bit has no role.
  logic unused_fill;
  assign unused_fill = fill_r;
  assign active_in   = dir_r ? sr_q[WIDTH-1] : sr_q[0];
`else
  // Fill mode: the captured fill bit enters on every shift cycle; the
  // register contents are not needed.
  logic unused_sr_q;
  assign unused_sr_q = ^sr_q;
  assign active_in   = fill_r;
`endif

  // State register.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command capture and shift counter. The counter is loaded with the
  // requested count on acceptance and steps down once per shift cycle.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      data_r <= '0;
      dir_r  <= 1'b0;
      fill_r <= 1'b0;
      cnt_r  <= '0;
    end else begin
      if (accept) begin
        data_r <= cmd_data;
        dir_r  <= cmd_dir;
        fill_r <= cmd_fill;
        cnt_r  <= cmd_count;
      end else if (state == S_SHIFT) begin
        cnt_r  <= cnt_r - CNT_W'(1);
      end
    end
  end

  // Next-state decode. LOAD skips straight to DONE for a zero count; SHIFT
  // leaves on the cycle that performs the last shift (counter at 1).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_r == '0) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_r == CNT_W'(1)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Moore output decode from state and captured fields. cmd_ready is also
  // gated by clear_n so no command can be offered acceptance while the
  // block is held in reset.
  always_comb begin
    select    = SEL_HOLD;
    par_out   = data_r;
    serial_R  = 1'b0;
    serial_L  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    cmd_ready = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = clear_n;
      end
      S_LOAD: begin
        select = SEL_LOAD;
        busy   = 1'b1;
      end
      S_SHIFT: begin
        select = shift_select(dir_r);
        busy   = 1'b1;
        if (dir_r) begin
          serial_L = active_in;
        end else begin
          serial_R = active_in;
        end
      end
      S_DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: begin
        select = SEL_HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer. Models the downstream 4-bit universal shift
// register, drives directed and random commands, and checks every cycle of
// each sequence plus the final register contents against values derived
// from the command with plain arithmetic.
module tb_shift_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             clear_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_fill;
  logic [WIDTH-1:0] sr = '0;
  logic [1:0]       select;
  logic [WIDTH-1:0] par_out;
  logic             serial_R;
  logic             serial_L;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .cmd_count (cmd_count),
    .cmd_fill  (cmd_fill),
    .sr_q      (sr),
    .select    (select),
    .par_out   (par_out),
    .serial_R  (serial_R),
    .serial_L  (serial_L),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Downstream universal shift register driven by the sequencer.
  always @(posedge clk) begin
    case (select)
      2'b01:   sr <= {serial_R, sr[WIDTH-1:1]};
      2'b10:   sr <= {sr[WIDTH-2:0], serial_L};
      2'b11:   sr <= par_out;
      default: sr <= sr;
    endcase
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register contents after load + count shifts, from closed-form arithmetic.
  function automatic logic [WIDTH-1:0] expect_final(input int d, input int dir,
                                                    input int cnt, input int fill);
    int mask;
    int r;
    int k;
    mask = (1 << WIDTH) - 1;
    r    = 0;
    k    = 0;
`ifdef SHIFT_SEQ_ROTATE_EN
    k = cnt % WIDTH;
    if (dir != 0) r = ((d << k) | (d >> (WIDTH - k))) & mask;
    else          r = ((d >> k) | (d << (WIDTH - k))) & mask;
`else
    if (cnt >= WIDTH)  r = (fill != 0) ? mask : 0;
    else if (dir != 0) r = ((d << cnt) & mask) | ((fill != 0) ? ((1 << cnt) - 1) : 0);
    else               r = (d >> cnt) | ((fill != 0) ? ((mask << (WIDTH - cnt)) & mask) : 0);
    k = fill + 0 * k;
`endif
    return r[WIDTH-1:0];
  endfunction

  // Waits (bounded) for cmd_ready with the command already presented, then
  // lets the accepting edge pass and returns at the LOAD-cycle negedge.
  task automatic accept_cmd(output int waited);
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_ready", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks a whole sequence starting at the LOAD-cycle negedge and ending at
  // the first IDLE negedge after done.
  task automatic check_sequence(input logic [WIDTH-1:0] d, input logic dir,
                                input int cnt, input logic fill, input bit scramble);
    logic [1:0] exp_sel;
    logic       act;
    chk("load_select", select, 3);
    chk("load_par_out", par_out, d);
    chk("load_busy", busy, 1);
    chk("load_ready", cmd_ready, 0);
    chk("load_done", done, 0);
    if (scramble) begin
      cmd_dir  = ~dir;
      cmd_fill = ~fill;
      cmd_data = WIDTH'($urandom);
    end
    exp_sel = dir ? 2'b10 : 2'b01;
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
`ifdef SHIFT_SEQ_ROTATE_EN
      act = dir ? sr[WIDTH-1] : sr[0];
`else
      act = fill;
`endif
      chk("shift_select", select, exp_sel);
      chk("shift_serial_R", serial_R, dir ? 1'b0 : act);
      chk("shift_serial_L", serial_L, dir ? act : 1'b0);
      chk("shift_busy", busy, 1);
      chk("shift_done", done, 0);
      chk("shift_ready", cmd_ready, 0);
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_select", select, 0);
    chk("done_busy", busy, 1);
    chk("done_ready", cmd_ready, 0);
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", cmd_ready, 1);
    chk("final_register", sr, expect_final(int'(d), int'(dir), cnt, int'(fill)));
  endtask

  task automatic run_cmd(input logic [WIDTH-1:0] d, input logic dir,
                         input int cnt, input logic fill);
    int w;
    cmd_data  = d;
    cmd_dir   = dir;
    cmd_count = CNT_W'(cnt);
    cmd_fill  = fill;
    cmd_valid = 1'b1;
    accept_cmd(w);
    cmd_valid = 1'b0;
    check_sequence(d, dir, cnt, fill, 1'b1);
  endtask

  initial begin
    int w;
    logic [WIDTH-1:0] rd;
    logic             rdir;
    logic             rfill;
    int               rcnt;

    clear_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_dir   = 1'b0;
    cmd_count = '0;
    cmd_fill  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_select", select, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_par_out", par_out, 0);
    chk("rst_serial_R", serial_R, 0);
    chk("rst_serial_L", serial_L, 0);
    clear_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);

    // Directed commands
    run_cmd(4'b1000, 1'b0, 2, 1'b1);
    run_cmd(4'b0011, 1'b1, 3, 1'b0);
    run_cmd(4'b0101, 1'b0, 0, 1'b1);
    run_cmd(4'b1001, 1'b0, 1, 1'b0);
    run_cmd(4'b1001, 1'b1, 1, 1'b0);
    run_cmd(4'b0110, 1'b0, 7, 1'b1);
    run_cmd(4'b1011, 1'b1, 6, 1'b0);
    run_cmd(4'b0110, 1'b1, 4, 1'b1);

    // Back-to-back with cmd_valid held high
    cmd_data  = 4'b1100;
    cmd_dir   = 1'b1;
    cmd_count = 3'd2;
    cmd_fill  = 1'b1;
    cmd_valid = 1'b1;
    accept_cmd(w);
    cmd_data  = 4'b0001;
    cmd_dir   = 1'b0;
    cmd_count = 3'd3;
    cmd_fill  = 1'b0;
    check_sequence(4'b1100, 1'b1, 2, 1'b1, 1'b0);
    accept_cmd(w);
    chk("b2b_gap", w, 0);
    cmd_valid = 1'b0;
    check_sequence(4'b0001, 1'b0, 3, 1'b0, 1'b1);

    // Reset asserted mid-shift
    cmd_data  = 4'b1111;
    cmd_dir   = 1'b0;
    cmd_count = 3'd6;
    cmd_fill  = 1'b0;
    cmd_valid = 1'b1;
    accept_cmd(w);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_pre_select", select, 1);
    clear_n = 1'b0;
    #1;
    chk("midrst_select", select, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", cmd_ready, 0);
    chk("midrst_par_out", par_out, 0);
    chk("midrst_serial_R", serial_R, 0);
    @(negedge clk);
    clear_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("postrst_done", done, 0);
      chk("postrst_busy", busy, 0);
      chk("postrst_ready", cmd_ready, 1);
    end

    // Random commands with random idle gaps
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rd    = WIDTH'($urandom);
      rdir  = 1'($urandom);
      rfill = 1'($urandom);
      rcnt  = int'($urandom_range(0, (1 << CNT_W) - 1));
      run_cmd(rd, rdir, rcnt, rfill);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
